// File: rtl/m_dmux_router.sv
// Registered 1-to-N demultiplexer: one tagged word stream steered to N
// single-entry valid/ready output channels, plus a wrapping accept counter.
module m_dmux_router #(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned SEL_BITS = 3
) (
  input  logic                            i_clk,
  input  logic                            i_rst,
  input  logic [WIDTH-1:0]                i_data,
  input  logic [SEL_BITS-1:0]             i_sel,
  input  logic                            i_valid,
  output logic                            o_ready,
  output logic [(WIDTH<<SEL_BITS)-1:0]    o_data,
  output logic [(1<<SEL_BITS)-1:0]        o_valid,
  input  logic [(1<<SEL_BITS)-1:0]        i_ready,
  output logic [15:0]                     o_accept_cnt,
  output logic                            o_busy
);

  localparam int unsigned N     = 1 << SEL_BITS;
  localparam int unsigned CNT_W = 16;

  logic [N-1:0]       valid_q, valid_d;
  logic [N*WIDTH-1:0] data_q, data_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               accept;

  // Ready only looks at the addressed channel, so a stalled channel never blocks others.
  assign o_ready = !valid_q[i_sel] || i_ready[i_sel];
  assign accept  = i_valid && o_ready && !i_rst;

  always_comb begin
    valid_d = valid_q & ~i_ready;
    data_d  = data_q;
    cnt_d   = cnt_q;
    if (accept) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    // An accept overrides a same-cycle drain on the target channel: no bubble.
    for (int unsigned k = 0; k < N; k++) begin
      if (accept && (i_sel == SEL_BITS'(k))) begin
        valid_d[k]                = 1'b1;
        data_d[k*WIDTH +: WIDTH]  = i_data;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      valid_q <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
    end
  end

  assign o_valid      = valid_q;
  assign o_data       = data_q;
  assign o_accept_cnt = cnt_q;
  assign o_busy       = |valid_q;

endmodule
